// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types: hazard FSM states and forwarding-select width helper.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // Select code 0 means regfile, k+1 means producer k.
    function automatic int fwdsel_w(input int nfwd);
        return $clog2(nfwd + 1);
    endfunction

    localparam int FWDSEL_W = fwdsel_w(2);

endpackage

// File: rtl/fwd_select.sv
// Priority encoder choosing the youngest producer whose destination matches one EX operand.
module fwd_select #(
    parameter int NREGW = 5,
    parameter int NFWD  = 2,
    parameter int SELW  = 2
) (
    input  logic [NREGW-1:0]            src,
    input  logic [NFWD-1:0]             wen,
    input  logic [NFWD-1:0][NREGW-1:0]  wsel,
    output logic [SELW-1:0]             sel
);

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        sel = '0;
        for (int j = NFWD - 1; j >= 0; j--) begin
            if (wen[j] && (wsel[j] != '0) && (wsel[j] == src)) begin
                sel = SELW'(j + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: operand forwarding, load-use/dmem-wait/branch stall engine
// and a saturating stall-cycle counter.
module hazard_ctrl_unit
    import cpu_types_pkg::*;
#(
    parameter int NREGW      = 5,
    parameter int NFWD       = 2,
    parameter int NOPS       = 2,
    parameter int LU_BUBBLES = 1,
    parameter int CNTW       = 16
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic [NOPS-1:0][NREGW-1:0]          ex_src,
    input  logic [NOPS-1:0][NREGW-1:0]          id_src,
    input  logic [NOPS-1:0]                     id_use,
    input  logic [NFWD-1:0]                     fwd_wen,
    input  logic [NFWD-1:0][NREGW-1:0]          fwd_wsel,
    input  logic                                ex_memread,
    input  logic [NREGW-1:0]                    ex_wsel,
    input  logic                                mem_req,
    input  logic                                dhit,
    input  logic                                branch_taken,
    input  logic                                cnt_clr,
    output logic [NOPS-1:0][fwdsel_w(NFWD)-1:0] fwd_sel,
    output logic                                freeze,
    output logic                                stall_if_id,
    output logic                                bubble_ex,
    output logic                                flush_if_id,
    output logic [CNTW-1:0]                     stall_cycles
);

    localparam int SELW = fwdsel_w(NFWD);

    hz_state_t             st, st_n, mode;
    logic [1:0]            bc, bc_n;
    logic                  lu, mw;
    logic                  freeze_c, stall_c, bubble_c, flush_c;
    logic [NOPS-1:0][SELW-1:0] sel_raw;

    for (genvar k = 0; k < NOPS; k++) begin : g_fwd
        fwd_select #(
            .NREGW (NREGW),
            .NFWD  (NFWD),
            .SELW  (SELW)
        ) u_fwd (
            .src  (ex_src[k]),
            .wen  (fwd_wen),
            .wsel (fwd_wsel),
            .sel  (sel_raw[k])
        );
    end

    always_comb begin
        lu = 1'b0;
        for (int k = 0; k < NOPS; k++) begin
            if (id_use[k] && (id_src[k] == ex_wsel)) lu = 1'b1;
        end
        lu = lu && ex_memread && (ex_wsel != '0);
    end

    assign mw = mem_req && !dhit;

    // On dmem release the cycle behaves like the state being returned to.
    always_comb begin
        mode = st;
        if (st == MEM_WAIT && !mw) mode = (bc != 2'd0) ? LU_STALL : RUN;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            st <= RUN;
            bc <= 2'd0;
        end else begin
            st <= st_n;
            bc <= bc_n;
        end
    end

    always_comb begin
        st_n = st;
        bc_n = bc;
        case (mode)
            RUN: begin
                st_n = RUN;
                if (mw) begin
                    st_n = MEM_WAIT;
                end else if (!branch_taken && lu && (LU_BUBBLES > 1)) begin
                    st_n = LU_STALL;
                    bc_n = 2'(LU_BUBBLES - 1);
                end
            end
            LU_STALL: begin
                st_n = LU_STALL;
                if (mw) begin
                    st_n = MEM_WAIT;
                end else if (bc <= 2'd1) begin
                    st_n = RUN;
                    bc_n = 2'd0;
                end else begin
                    bc_n = bc - 2'd1;
                end
            end
            MEM_WAIT: st_n = MEM_WAIT;
            default: begin
                st_n = RUN;
                bc_n = 2'd0;
            end
        endcase
    end

    always_comb begin
        freeze_c = 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        case (mode)
            RUN: begin
                if (mw) begin
                    freeze_c = 1'b1;
                end else if (branch_taken) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (lu) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            LU_STALL: begin
                if (mw) begin
                    freeze_c = 1'b1;
                end else begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            MEM_WAIT: freeze_c = 1'b1;
            default: ;
        endcase
    end

    assign fwd_sel     = nRST ? sel_raw : '0;
    assign freeze      = nRST && freeze_c;
    assign stall_if_id = nRST && stall_c;
    assign bubble_ex   = nRST && bubble_c;
    assign flush_if_id = nRST && flush_c;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if ((freeze || stall_if_id) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (LU_BUBBLES=2, CNTW=4): vector table plus multi-cycle sequences.
module tb_hazard_ctrl_unit;

    logic             CLK;
    logic             nRST;
    logic [1:0][4:0]  ex_src;
    logic [1:0][4:0]  id_src;
    logic [1:0]       id_use;
    logic [1:0]       fwd_wen;
    logic [1:0][4:0]  fwd_wsel;
    logic             ex_memread;
    logic [4:0]       ex_wsel;
    logic             mem_req;
    logic             dhit;
    logic             branch_taken;
    logic             cnt_clr;
    logic [1:0][1:0]  fwd_sel;
    logic             freeze;
    logic             stall_if_id;
    logic             bubble_ex;
    logic             flush_if_id;
    logic [3:0]       stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_unit #(
        .NREGW(5), .NFWD(2), .NOPS(2), .LU_BUBBLES(2), .CNTW(4)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ex_src(ex_src), .id_src(id_src), .id_use(id_use),
        .fwd_wen(fwd_wen), .fwd_wsel(fwd_wsel), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
        .mem_req(mem_req), .dhit(dhit), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_sel), .freeze(freeze), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .stall_cycles(stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] ex_src0, ex_src1, id_src0, id_src1;
        logic [1:0] id_use, wen;
        logic [4:0] wsel0, wsel1;
        logic       memread;
        logic [4:0] ex_wsel;
        logic       branch;
        int         e_fwd0, e_fwd1, e_stall, e_bubble, e_flush;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        ex_src = '0; id_src = '0; id_use = '0; fwd_wen = '0; fwd_wsel = '0;
        ex_memread = 1'b0; ex_wsel = '0; mem_req = 1'b0; dhit = 1'b0;
        branch_taken = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    // Load r3 in EX while ID reads r3 as operand 1.
    task automatic set_lu();
        ex_memread = 1'b1; ex_wsel = 5'd3; id_src[1] = 5'd3; id_use = 2'b10;
    endtask

    task automatic chk_ctl(input string tag, input int fz, input int st, input int bb, input int fl);
        chk({tag, ".freeze"}, int'(freeze), fz);
        chk({tag, ".stall"},  int'(stall_if_id), st);
        chk({tag, ".bubble"}, int'(bubble_ex), bb);
        chk({tag, ".flush"},  int'(flush_if_id), fl);
    endtask

    initial begin
        //           exs0 exs1 ids0 ids1 use    wen    ws0 ws1 mrd ewsel br  f0 f1 st bb fl
        vecs[0]  = '{5,  0,   0,   0,   2'b00, 2'b11, 5,  5,  0,  0,    0,  1, 0, 0, 0, 0};
        vecs[1]  = '{5,  0,   0,   0,   2'b00, 2'b10, 5,  5,  0,  0,    0,  2, 0, 0, 0, 0};
        vecs[2]  = '{0,  0,   0,   0,   2'b00, 2'b11, 0,  0,  0,  0,    0,  0, 0, 0, 0, 0};
        vecs[3]  = '{7,  9,   0,   0,   2'b00, 2'b11, 9,  7,  0,  0,    0,  2, 1, 0, 0, 0};
        vecs[4]  = '{7,  9,   0,   0,   2'b00, 2'b00, 9,  7,  0,  0,    0,  0, 0, 0, 0, 0};
        vecs[5]  = '{31, 31,  0,   0,   2'b00, 2'b01, 31, 31, 0,  0,    0,  1, 1, 0, 0, 0};
        vecs[6]  = '{0,  0,   0,   3,   2'b10, 2'b00, 0,  0,  1,  3,    1,  0, 0, 0, 1, 1};
        vecs[7]  = '{0,  0,   0,   3,   2'b00, 2'b00, 0,  0,  1,  3,    0,  0, 0, 0, 0, 0};
        vecs[8]  = '{0,  0,   0,   0,   2'b01, 2'b00, 0,  0,  1,  0,    0,  0, 0, 0, 0, 0};
        vecs[9]  = '{0,  0,   0,   3,   2'b10, 2'b00, 0,  0,  0,  3,    0,  0, 0, 0, 0, 0};
        vecs[10] = '{0,  0,   0,   0,   2'b00, 2'b00, 0,  0,  0,  0,    1,  0, 0, 0, 1, 1};

        // Reset: outputs forced low even with hazards and matches present.
        idle();
        nRST = 1'b0;
        ex_src[0] = 5'd5; fwd_wen = 2'b11; fwd_wsel[0] = 5'd5; branch_taken = 1'b1;
        mem_req = 1'b1;
        #2;
        chk("rst.fwd0", int'(fwd_sel[0]), 0);
        chk_ctl("rst", 0, 0, 0, 0);
        chk("rst.cnt", int'(stall_cycles), 0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        idle();
        next_cyc();

        for (int i = 0; i < 11; i++) begin
            ex_src[0] = vecs[i].ex_src0; ex_src[1] = vecs[i].ex_src1;
            id_src[0] = vecs[i].id_src0; id_src[1] = vecs[i].id_src1;
            id_use = vecs[i].id_use; fwd_wen = vecs[i].wen;
            fwd_wsel[0] = vecs[i].wsel0; fwd_wsel[1] = vecs[i].wsel1;
            ex_memread = vecs[i].memread; ex_wsel = vecs[i].ex_wsel;
            branch_taken = vecs[i].branch;
            #3;
            chk($sformatf("vec%0d.fwd0", i), int'(fwd_sel[0]), vecs[i].e_fwd0);
            chk($sformatf("vec%0d.fwd1", i), int'(fwd_sel[1]), vecs[i].e_fwd1);
            chk_ctl($sformatf("vec%0d", i), 0, vecs[i].e_stall, vecs[i].e_bubble, vecs[i].e_flush);
            next_cyc();
        end

        // Two-bubble load-use stall.
        idle(); cnt_clr = 1'b1; next_cyc();
        chk("lu.cnt0", int'(stall_cycles), 0);
        idle(); set_lu(); #3; chk_ctl("lu.c1", 0, 1, 1, 0); next_cyc();
        idle(); #3; chk_ctl("lu.c2", 0, 1, 1, 0); next_cyc();
        idle(); #3; chk_ctl("lu.c3", 0, 0, 0, 0);
        chk("lu.cnt", int'(stall_cycles), 2);
        next_cyc();

        // Dmem wait arriving mid load-use stall.
        idle(); cnt_clr = 1'b1; next_cyc();
        idle(); set_lu(); #3; chk_ctl("mw.c1", 0, 1, 1, 0); next_cyc();
        for (int c = 0; c < 4; c++) begin
            idle(); mem_req = 1'b1; #3;
            chk_ctl($sformatf("mw.frz%0d", c), 1, 0, 0, 0);
            next_cyc();
        end
        idle(); mem_req = 1'b1; dhit = 1'b1; #3; chk_ctl("mw.hit", 0, 1, 1, 0); next_cyc();
        idle(); #3; chk_ctl("mw.after", 0, 0, 0, 0);
        chk("mw.cnt", int'(stall_cycles), 6);
        next_cyc();

        // Branch held during a dmem freeze flushes only on release.
        idle(); cnt_clr = 1'b1; next_cyc();
        idle(); mem_req = 1'b1; branch_taken = 1'b1; #3; chk_ctl("br.f1", 1, 0, 0, 0); next_cyc();
        #3; chk_ctl("br.f2", 1, 0, 0, 0); next_cyc();
        dhit = 1'b1; #3; chk_ctl("br.hit", 0, 0, 1, 1); next_cyc();
        idle(); #3; chk_ctl("br.after", 0, 0, 0, 0); next_cyc();

        // Counter saturation with CNTW=4, then clear taking priority over increment.
        idle(); cnt_clr = 1'b1; next_cyc();
        idle(); mem_req = 1'b1;
        for (int c = 0; c < 20; c++) next_cyc();
        #3; chk("sat.cnt", int'(stall_cycles), 15);
        chk("sat.freeze", int'(freeze), 1);
        cnt_clr = 1'b1; next_cyc();
        #3; chk("sat.clr", int'(stall_cycles), 0);
        cnt_clr = 1'b0; dhit = 1'b1; next_cyc();
        idle(); next_cyc();

        // Reset pulse while in LU_STALL.
        idle(); set_lu(); next_cyc();
        idle(); #2; chk("rstmid.pre", int'(stall_if_id), 1);
        nRST = 1'b0; #1;
        chk_ctl("rstmid.low", 0, 0, 0, 0);
        chk("rstmid.cnt", int'(stall_cycles), 0);
        nRST = 1'b1; #1;
        chk_ctl("rstmid.rel", 0, 0, 0, 0);
        next_cyc();
        #3; chk_ctl("rstmid.run", 0, 0, 0, 0);
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
